// File: rtl/value_sampler_pkg.sv
// Shared widths and types for the value sampler and its FIFO.
package value_sampler_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DROP_CNT_W    = 8;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

endpackage

// File: rtl/value_sampler_sync_fifo.sv
// sync_fifo: first-word-fall-through storage with wrapping pointers and an occupancy counter.
// Latency: a write at edge N is visible on rdata after edge N; no bypass when empty.
// Backpressure: caller must gate push with full (unless popping) and pop with !empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [WIDTH-1:0]           rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  // Storage is intentionally left unreset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/value_sampler.sv
// value_sampler: records enabled counter samples that differ from the last candidate into a FIFO.
// Latency: accepted sample appears on out_data one cycle after its push edge.
// Backpressure: out_valid/out_ready drain; pushes into a full, non-popping FIFO are dropped and flag overflow
// (plus drop_count when VALUE_SAMPLER_DROP_CNT_EN is defined).
module value_sampler
  import value_sampler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_value,
  input  logic                   in_en,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef VALUE_SAMPLER_DROP_CNT_EN
  ,
  output drop_cnt_t              drop_count
`endif
);

  logic             primed;
  logic [WIDTH-1:0] last;
  logic             candidate;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             full;
  logic             empty;

  assign candidate = in_en && (!primed || (in_value != last));
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign accept    = candidate && (!full || pop);
  assign drop      = candidate && full && !pop;
  assign out_valid = !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      primed   <= 1'b0;
      last     <= '0;
      overflow <= 1'b0;
    end else begin
      if (candidate) begin
        primed <= 1'b1;
        last   <= in_value;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef VALUE_SAMPLER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end
`endif

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (in_value),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .level (level),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_value_sampler.sv
// Scoreboard bench for value_sampler: directed stimulus queues expected samples, a monitor checks drained data.
module tb_value_sampler;
  import value_sampler_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_value = '0;
  logic       in_en = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] level;
  logic       overflow;
`ifdef VALUE_SAMPLER_DROP_CNT_EN
  drop_cnt_t  drop_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb [$];

  value_sampler #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_value  (in_value),
    .in_en     (in_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
`ifdef VALUE_SAMPLER_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every handshake must match the oldest expected sample.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL drain: got %0d, expected no output", out_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          miscompares++;
          $display("FAIL drain: got %0d, expected %0d", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [7:0] v, input logic rdy);
    in_en = en;
    in_value = v;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_en = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
`ifdef VALUE_SAMPLER_DROP_CNT_EN
    chk("rst_drop_count", drop_count, 0);
`endif

    // Repeated value recorded once
    sb.push_back(8'd5);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd5, 1'b0);
    chk("dup_level", level, 1);
    chk("dup_valid", out_valid, 1);
    chk("dup_data", out_data, 5);
    step(1'b0, 8'd5, 1'b1);
    chk("dup_drained_level", level, 0);

    // Fill to DEPTH, then one dropped push
    for (int v = 1; v <= 4; v++) begin
      sb.push_back(8'(v));
      step(1'b1, 8'(v), 1'b0);
    end
    chk("fill_level", level, 4);
    chk("fill_overflow", overflow, 0);
    step(1'b1, 8'd5, 1'b0);
    chk("drop_level", level, 4);
    chk("drop_overflow", overflow, 1);
`ifdef VALUE_SAMPLER_DROP_CNT_EN
    chk("drop_count", drop_count, 1);
`endif

    // Full with simultaneous pop: push accepted
    sb.push_back(8'd9);
    step(1'b1, 8'd9, 1'b1);
    chk("fullpop_level", level, 4);
    chk("fullpop_overflow", overflow, 1);
`ifdef VALUE_SAMPLER_DROP_CNT_EN
    chk("fullpop_drop_count", drop_count, 1);
`endif
    for (int i = 0; i < 5; i++) step(1'b0, 8'd9, 1'b1);
    chk("fullpop_drained", level, 0);
    chk("fullpop_sb_empty", sb.size(), 0);

    // Counter ramp with wrap, sustained push+pop
    do_reset();
    chk("ramp_rst_overflow", overflow, 0);
    for (int v = 0; v <= 256; v++) begin
      sb.push_back(8'(v));
      step(1'b1, 8'(v), 1'b1);
      if (v == 0) begin
        chk("ramp_first_valid", out_valid, 1);
        chk("ramp_first_data", out_data, 0);
      end
    end
    chk("ramp_level", level, 1);
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);
    chk("ramp_drained", level, 0);
    chk("ramp_sb_empty", sb.size(), 0);
    chk("ramp_overflow", overflow, 0);

    // Reset mid-operation discards contents and re-arms change detection
    sb.push_back(8'd10);
    step(1'b1, 8'd10, 1'b0);
    sb.push_back(8'd11);
    step(1'b1, 8'd11, 1'b0);
    sb.push_back(8'd12);
    step(1'b1, 8'd12, 1'b0);
    chk("pre_rst_level", level, 3);
    do_reset();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_level", level, 0);
    sb.push_back(8'd12);
    step(1'b1, 8'd12, 1'b0);
    chk("rearm_level", level, 1);
    chk("rearm_data", out_data, 12);
    step(1'b0, 8'd12, 1'b1);
    chk("rearm_drained", level, 0);

    // Disabled cycles ignore the input and leave last intact
    step(1'b0, 8'd20, 1'b0);
    step(1'b0, 8'd30, 1'b0);
    chk("disabled_level", level, 0);
    chk("disabled_valid", out_valid, 0);
    step(1'b1, 8'd12, 1'b0);
    chk("reenable_same_level", level, 0);
    sb.push_back(8'd13);
    step(1'b1, 8'd13, 1'b0);
    chk("reenable_new_level", level, 1);
    step(1'b0, 8'd13, 1'b1);
    step(1'b0, 8'd13, 1'b0);
    chk("final_level", level, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
